tp2_session_ctrl: RTL and testbench
===================================

Name: tp2_session_ctrl

Overview:
- Session controller that sequences the note-sequence recognizer FSM.
- Holds the recognizer in reset between attempts and gates the user "ok" button into it.
- Detects inactivity timeouts and latches the final result (past/infinitive/future/none).
- Counts consecutive failed attempts and imposes a lockout after too many.
- Sits between the board inputs (start/ok buttons) and the recognizer's clk/reset/ok/finish/type pins.

Parameters:
- TIMEOUT_CYCLES, 1000: max cycles in RUN without a rising edge on ok before the attempt fails.
- LOCK_CYCLES, 5000: lockout duration in cycles after MAX_ERRORS consecutive failures.
- CLEAR_CYCLES, 2: cycles rec_reset is held high in CLEAR. Must be ≥1.
- MAX_ERRORS, 3: consecutive failures that trigger lockout. Range 1..7.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; sampled each cycle; requests a new attempt.
- ok  in  1  raw user confirm button.
- rec_finish  in  1  recognizer finish output.
- rec_type  in  2  recognizer type output (00 none/error, 01 past, 10 infinitive, 11 future).
- rec_reset  out  1  reset to recognizer; registered.
- ok_out  out  1  gated ok to recognizer; equals ok in RUN, else 0 (combinational from state and ok).
- result_valid  out  1  result_type holds a completed attempt's result.
- result_type  out  2  latched result of last attempt.
- timeout  out  1  last attempt ended by inactivity timeout.
- err_count  out  3  consecutive failed attempts.
- locked  out  1  lockout in progress.
- busy  out  1  high in CLEAR, RUN, RESULT.

Behaviour:
- Reset, applied in any state at the next posedge:
  - State goes to IDLE.
  - rec_reset=1; ok_out=0; result_valid=0; result_type=00; timeout=0; err_count=0; locked=0; busy=0.
  - All timers cleared. Reset mid-RUN or mid-LOCK aborts without recording a result.
- States are IDLE, CLEAR, RUN, RESULT and LOCK. All outputs except ok_out are registered.
- IDLE:
  - rec_reset=1.
  - start=1 → CLEAR. result_valid and timeout are cleared on this transition.
- CLEAR:
  - rec_reset=1 for exactly CLEAR_CYCLES cycles, then → RUN.
  - start is ignored. rec_finish is ignored.
  - Example: start sampled high in cycle N gives CLEAR during N+1..N+CLEAR_CYCLES and RUN from N+CLEAR_CYCLES+1.
- RUN, ok handling:
  - rec_reset=0; ok_out=ok.
  - An internal prev_ok register detects rising edges of ok.
  - The inactivity timer resets to 0 on RUN entry and on every detected rising edge; otherwise it increments.
- RUN, exits:
  - rec_finish=1 → RESULT. Latch result_type=rec_type, timeout=0.
  - Timer reaches TIMEOUT_CYCLES-1 with no edge that cycle → RESULT. Latch result_type=00, timeout=1.
  - rec_finish and timeout in the same cycle: finish wins.
  - start=1 in RUN aborts the attempt → CLEAR. No result is recorded and err_count is unchanged. Abort has priority over finish and timeout.
- RESULT (exactly 1 cycle):
  - result_valid=1 from this cycle and stays high until the next IDLE→CLEAR transition or reset.
  - If result_type≠00: err_count=0, → IDLE.
  - If result_type=00: err_count=err_count+1. If the new value equals MAX_ERRORS → LOCK, else → IDLE.
- LOCK:
  - locked=1; rec_reset=1; start is ignored.
  - Stays for exactly LOCK_CYCLES cycles.
  - On exit: err_count=0, locked=0, → IDLE. result_valid, result_type and timeout are retained.
- Width rules:
  - Timer and lock counters are $clog2(max(TIMEOUT_CYCLES, LOCK_CYCLES)+1) bits.
  - err_count never exceeds MAX_ERRORS.
- Latency:
  - rec_finish in cycle M gives result_valid=1 at M+1.
  - The controller is back in IDLE (or LOCK) at M+2.

Test Plan:
(Params TIMEOUT_CYCLES=20, LOCK_CYCLES=10, CLEAR_CYCLES=2, MAX_ERRORS=3.)
1. Reset, then start pulsed in cycle 0 → rec_reset=1 in cycles 1–2, RUN and rec_reset=0 from cycle 3, busy=1. Toggling ok then shows ok_out following ok.
2. In RUN, rec_finish=1 with rec_type=10 in cycle M → at M+1 result_valid=1, result_type=10, timeout=0, err_count=0. IDLE at M+2, rec_reset=1.
3. In RUN, no ok edges for 20 cycles → result_type=00, timeout=1, err_count=1, IDLE. Repeat with one ok edge every 15 cycles → no timeout.
4. Three consecutive failures (two rec_type=00, one timeout) → err_count=3, locked=1 for 10 cycles while start is held high and ignored. Then err_count=0, locked=0, IDLE.
5. Two failures then success rec_type=01 → err_count resets to 0, result_type=01. Start pulsed in RUN aborts to CLEAR with err_count unchanged and no result_valid.
6. Edge cases:
   - rec_finish and timeout in the same cycle → result_type=rec_type, timeout=0.
   - reset asserted mid-LOCK → next cycle IDLE, locked=0, err_count=0, result_valid=0.

Source files
------------

// File: rtl/tp2_session_ctrl.sv
// Session sequencer for the note-sequence recognizer: clears it, gates ok, latches the result, counts failures, enforces lockout.
// Outputs registered except ok_out; result_valid one cycle after rec_finish, IDLE/LOCK the cycle after that.
module tp2_session_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int LOCK_CYCLES    = 5000,
    parameter int CLEAR_CYCLES   = 2,
    parameter int MAX_ERRORS     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ok,
    input  logic       rec_finish,
    input  logic [1:0] rec_type,
    output logic       rec_reset,
    output logic       ok_out,
    output logic       result_valid,
    output logic [1:0] result_type,
    output logic       timeout,
    output logic [2:0] err_count,
    output logic       locked,
    output logic       busy
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > LOCK_CYCLES) ? TIMEOUT_CYCLES : LOCK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CLEAR_LAST   = CW'(CLEAR_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST    = CW'(LOCK_CYCLES - 1);
    localparam logic [2:0]    ERR_LIMIT    = 3'(MAX_ERRORS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_RESULT,
        S_LOCK
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          prev_ok;
    logic          ok_rise;
    logic          result_valid_nxt;
    logic [1:0]    result_type_nxt;
    logic          timeout_nxt;
    logic [2:0]    err_count_nxt;
    logic [2:0]    err_inc;

    assign ok_out = (state == S_RUN) & ok;

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        result_valid_nxt = result_valid;
        result_type_nxt  = result_type;
        timeout_nxt      = timeout;
        err_count_nxt    = err_count;
        ok_rise          = ok & ~prev_ok;
        err_inc          = err_count + 3'd1;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt        = S_CLEAR;
                    cnt_nxt          = '0;
                    result_valid_nxt = 1'b0;
                    timeout_nxt      = 1'b0;
                end
            end
            S_CLEAR: begin
                if (cnt == CLEAR_LAST) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RUN: begin
                // Abort beats finish, finish beats the inactivity timeout.
                if (start) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = '0;
                end else if (rec_finish) begin
                    state_nxt        = S_RESULT;
                    result_valid_nxt = 1'b1;
                    result_type_nxt  = rec_type;
                    timeout_nxt      = 1'b0;
                end else if (ok_rise) begin
                    cnt_nxt = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt        = S_RESULT;
                    result_valid_nxt = 1'b1;
                    result_type_nxt  = 2'b00;
                    timeout_nxt      = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RESULT: begin
                state_nxt = S_IDLE;
                if (result_type != 2'b00) begin
                    err_count_nxt = 3'd0;
                end else begin
                    err_count_nxt = err_inc;
                    if (err_inc == ERR_LIMIT) begin
                        state_nxt = S_LOCK;
                        cnt_nxt   = '0;
                    end
                end
            end
            S_LOCK: begin
                if (cnt == LOCK_LAST) begin
                    state_nxt     = S_IDLE;
                    err_count_nxt = 3'd0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status flags are derived from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            prev_ok      <= 1'b0;
            rec_reset    <= 1'b1;
            result_valid <= 1'b0;
            result_type  <= 2'b00;
            timeout      <= 1'b0;
            err_count    <= 3'd0;
            locked       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            prev_ok      <= ok;
            rec_reset    <= (state_nxt != S_RUN);
            result_valid <= result_valid_nxt;
            result_type  <= result_type_nxt;
            timeout      <= timeout_nxt;
            err_count    <= err_count_nxt;
            locked       <= (state_nxt == S_LOCK);
            busy         <= (state_nxt == S_CLEAR) || (state_nxt == S_RUN) || (state_nxt == S_RESULT);
        end
    end

endmodule

// File: tb/tb_tp2_session_ctrl.sv
// Scoreboard bench for tp2_session_ctrl: attempts are modelled at transaction level, results are checked by a monitor.
module tb_tp2_session_ctrl;
    localparam int T  = 20;
    localparam int L  = 10;
    localparam int C  = 2;
    localparam int ME = 3;

    logic       clk = 1'b0;
    logic       reset, start, ok, rec_finish;
    logic [1:0] rec_type;
    logic       rec_reset, ok_out, result_valid, timeout, locked, busy;
    logic [1:0] result_type;
    logic [2:0] err_count;

    tp2_session_ctrl #(
        .TIMEOUT_CYCLES(T), .LOCK_CYCLES(L), .CLEAR_CYCLES(C), .MAX_ERRORS(ME)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .ok(ok), .rec_finish(rec_finish),
        .rec_type(rec_type), .rec_reset(rec_reset), .ok_out(ok_out),
        .result_valid(result_valid), .result_type(result_type), .timeout(timeout),
        .err_count(err_count), .locked(locked), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] rtype;
        logic       tmo;
        int         at;
        logic [2:0] err;
        logic       lk;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int   m_err = 0;      // consecutive failures as the model sees them
    logic last_ok = 1'b0; // ok as presented in the previous cycle
    logic exp_rv = 1'b0;
    bit   lock_reset = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every new result_valid rise must match the oldest expectation, then the
    // follow-up error count / lock state one cycle later.
    logic rv_q = 1'b0;
    always begin
        @(negedge clk);
        if (result_valid === 1'b1 && rv_q !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got result_type %0d with nothing pending (cycle %0d)", result_type, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result_type", result_type, mon_e.rtype);
                chk("result_timeout", timeout, mon_e.tmo);
                chk("result_latency", cyc, mon_e.at);
                @(negedge clk);
                chk("post_err_count", err_count, mon_e.err);
                chk("post_locked", locked, mon_e.lk);
            end
        end
        rv_q = result_valid;
    end

    task automatic lock_phase();
        for (int i = 0; i < L; i++) begin
            start = 1'b1;
            ok = 1'($urandom_range(0, 1));
            #1;
            chk("lock_locked", locked, 1);
            chk("lock_rec_reset", rec_reset, 1);
            chk("lock_busy", busy, 0);
            chk("lock_ok_gate", ok_out, 0);
            chk("lock_err", err_count, ME);
            if (lock_reset && i == 4) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                start = 1'b0;
                chk("rst_lock_locked", locked, 0);
                chk("rst_lock_err", err_count, 0);
                chk("rst_lock_rv", result_valid, 0);
                chk("rst_lock_rtype", result_type, 0);
                chk("rst_lock_busy", busy, 0);
                chk("rst_lock_rec_reset", rec_reset, 1);
                m_err = 0;
                exp_rv = 1'b0;
                lock_reset = 0;
                return;
            end
            step();
        end
        start = 1'b0;
        chk("unlock_locked", locked, 0);
        chk("unlock_err", err_count, 0);
        chk("unlock_rv_kept", result_valid, 1);
        chk("unlock_busy", busy, 0);
        chk("unlock_rec_reset", rec_reset, 1);
        m_err = 0;
    endtask

    task automatic finish_result(input logic [1:0] rtype, input logic tmo);
        exp_t e;
        m_err = (rtype == 2'b00) ? m_err + 1 : 0;
        e.rtype = rtype;
        e.tmo   = tmo;
        e.at    = cyc + 1;
        e.err   = 3'(m_err);
        e.lk    = (m_err == ME);
        exp_q.push_back(e);
        step();
        rec_finish = 1'b0;
        start = 1'b0;
        ok = 1'b0;
        exp_rv = 1'b1;
        chk("result_busy", busy, 1);
        step();
        if (e.lk) begin
            lock_phase();
        end else begin
            chk("after_busy", busy, 0);
            chk("after_rec_reset", rec_reset, 1);
            chk("after_rv", result_valid, 1);
            chk("after_err", err_count, m_err);
        end
    endtask

    task automatic idle_start();
        start = 1'b1;
        ok = 1'($urandom_range(0, 1));
        rec_finish = 1'($urandom_range(0, 1));
        rec_type = 2'($urandom_range(0, 3));
        #1;
        chk("idle_ok_gate", ok_out, 0);
        chk("idle_rec_reset", rec_reset, 1);
        chk("idle_busy", busy, 0);
        last_ok = ok;
        step();
        exp_rv = 1'b0;
        chk("start_clears_rv", result_valid, 0);
        chk("start_clears_timeout", timeout, 0);
    endtask

    task automatic clear_phase();
        for (int k = 0; k < C; k++) begin
            start = 1'($urandom_range(0, 1));
            ok = 1'($urandom_range(0, 1));
            rec_finish = 1'($urandom_range(0, 1));
            #1;
            chk("clear_rec_reset", rec_reset, 1);
            chk("clear_busy", busy, 1);
            chk("clear_ok_gate", ok_out, 0);
            chk("clear_rv", result_valid, exp_rv);
            last_ok = ok;
            step();
        end
    endtask

    task automatic run_phase(input int per, input int f, input logic [1:0] ftype,
                             input int abort_at, input bit noise, output bit aborted);
        int   quiet = 0;
        logic rise;
        aborted = 0;
        for (int i = 0; i <= f; i++) begin
            ok = (per != 0 && (i % per) == per - 1) || (noise && per != 0 && $urandom_range(0, 7) == 0);
            start = (i == abort_at);
            rec_finish = (i == f);
            rec_type = (i == f) ? ftype : 2'($urandom_range(0, 3));
            #1;
            chk("run_ok_out", ok_out, ok);
            chk("run_rec_reset", rec_reset, 0);
            chk("run_busy", busy, 1);
            rise = ok && !last_ok;
            last_ok = ok;
            if (start) begin
                aborted = 1;
                step();
                start = 1'b0;
                chk("abort_busy", busy, 1);
                chk("abort_rec_reset", rec_reset, 1);
                chk("abort_rv", result_valid, 0);
                chk("abort_err", err_count, m_err);
                return;
            end
            if (rec_finish) begin
                finish_result(ftype, 1'b0);
                return;
            end
            quiet = rise ? 0 : quiet + 1;
            if (quiet == T) begin
                finish_result(2'b00, 1'b1);
                return;
            end
            step();
        end
    endtask

    task automatic attempt(input int per, input int f, input logic [1:0] ftype,
                           input int abort_at, input bit noise);
        bit ab;
        idle_start();
        clear_phase();
        run_phase(per, f, ftype, abort_at, noise, ab);
        if (ab) begin
            clear_phase();
            run_phase(per, f, ftype, -1, noise, ab);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; ok = 1'b1; rec_finish = 1'b0; rec_type = 2'b00;
        step();
        step();
        chk("rst_rec_reset", rec_reset, 1);
        chk("rst_ok_out", ok_out, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_rtype", result_type, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_err", err_count, 0);
        chk("rst_locked", locked, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        ok = 1'b0;
        step();

        attempt(4, 5, 2'b10, -1, 0);     // success, infinitive
        attempt(0, 40, 2'b01, -1, 0);    // inactivity timeout
        attempt(15, 40, 2'b11, -1, 0);   // edge every 15 cycles keeps it alive
        attempt(0, 3, 2'b00, -1, 0);     // three failures in a row -> lockout
        attempt(4, 6, 2'b00, -1, 0);
        attempt(0, 40, 2'b10, -1, 0);
        attempt(5, 4, 2'b00, -1, 0);     // two failures then success
        attempt(0, 50, 2'b00, -1, 0);
        attempt(3, 7, 2'b01, -1, 0);
        attempt(4, 8, 2'b10, 3, 0);      // abort in RUN then complete
        attempt(0, T - 1, 2'b01, -1, 0); // finish on the timeout cycle

        for (int n = 0; n < 30; n++) begin
            int per, f, ty, ab, gap;
            per = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(3, 25);
            f   = $urandom_range(0, 45);
            ty  = $urandom_range(0, 3);
            ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 10) : -1;
            attempt(per, f, 2'(ty), ab, 1);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                start = 1'b0;
                ok = 1'($urandom_range(0, 1));
                rec_finish = 1'($urandom_range(0, 1));
                step();
            end
        end

        lock_reset = 1;
        for (int n = 0; n < ME + 1 && lock_reset; n++)
            attempt(0, $urandom_range(0, 10), 2'b00, -1, 0);

        step();
        step();
        step();
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
